// File: rtl/stream_pkg.sv
// Shared types and widths for the byte-to-word packing path.
package stream_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    PEND  = 2'd2
  } state_t;

  // SWAP=0 puts the first byte in the low half; SWAP=1 puts it in the high half.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] first,
                                                  input logic [BYTE_W-1:0] second,
                                                  input logic              swap);
    return swap ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/word_out_reg.sv
// Output word register with valid/ready handshake; reports when it can take a new word.
module word_out_reg
  import stream_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_padded,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_padded,
  output logic              out_free
);

  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              padded_q, padded_d;

  // A load in the same cycle as a handshake replaces the word with no bubble.
  always_comb begin
    data_d   = data_q;
    padded_d = padded_q;
    valid_d  = valid_q && !out_ready;
    if (load) begin
      data_d   = load_data;
      padded_d = load_padded;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      padded_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      padded_q <= padded_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_padded = padded_q;
  assign out_free   = !valid_q || out_ready;

endmodule

// File: rtl/byte_pair_packer.sv
// Packs a valid/ready byte stream into 16-bit words, padding odd-length packets.
module byte_pair_packer
  import stream_pkg::*;
#(
  parameter bit               SWAP = 1'b0,
  parameter logic [BYTE_W-1:0] PAD = 8'h00
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_padded,
  input  logic              out_ready,
  output logic [15:0]       word_count,
  output state_t            dbg_state
);

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid && ready; the sender holds data/valid stable until that edge.

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] first_q, first_d;
  logic [15:0]       word_count_q, word_count_d;

  logic              accept;
  logic              load;
  logic [WORD_W-1:0] load_data;
  logic              load_padded;
  logic              out_free;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= EMPTY;
      first_q      <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = in_last ? PEND : HALF;
      HALF:    if (accept) state_d = EMPTY;
      PEND:    if (out_free) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    load        = 1'b0;
    load_padded = 1'b0;
    load_data   = pack_word(first_q, in_data, SWAP);
    first_d     = first_q;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) first_d = in_data;
      end
      HALF: begin
        in_ready = out_free;
        load     = in_valid && out_free;
      end
      PEND: begin
        load        = out_free;
        load_padded = 1'b1;
        load_data   = pack_word(first_q, PAD, SWAP);
      end
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    word_count_d = word_count_q;
    if (out_valid && out_ready) word_count_d = word_count_q + 16'd1;
  end

  word_out_reg u_out (
    .clk         (CLK),
    .reset       (RESET),
    .load        (load),
    .load_data   (load_data),
    .load_padded (load_padded),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_padded  (out_padded),
    .out_free    (out_free)
  );

  assign word_count = word_count_q;
  assign dbg_state  = state_q;

endmodule
